// File: rtl/memory_pipelined_uram_be_if.sv
// ---------------------------------------------------------------------------
// memory_pipelined_uram_be_if
// Purpose : bundles the read/write request signals and the read-return
//           signals of the pipelined UltraRAM buffer.
// Signals : CSB_read/A_read   - read strobe (active high) and address
//           CSB_write/A_write - write strobe (active high) and address
//           WEB               - per-byte write enable, bit k covers I[8k+7:8k]
//           I                 - write data
//           OEB               - output enable, active low (1 forces O to 0)
//           O/O_valid/O_oor   - read data, slot valid, slot out-of-range
// Modports: master drives requests, slave (the memory) returns read data.
// ---------------------------------------------------------------------------
interface memory_pipelined_uram_be_if #(
    parameter int DW = 512,
    parameter int AW = 9
);
    logic            CSB_read;
    logic [AW-1:0]   A_read;
    logic            CSB_write;
    logic [DW/8-1:0] WEB;
    logic [AW-1:0]   A_write;
    logic [DW-1:0]   I;
    logic            OEB;
    logic [DW-1:0]   O;
    logic            O_valid;
    logic            O_oor;

    modport master (
        output CSB_read, A_read, CSB_write, WEB, A_write, I, OEB,
        input  O, O_valid, O_oor
    );

    modport slave (
        input  CSB_read, A_read, CSB_write, WEB, A_write, I, OEB,
        output O, O_valid, O_oor
    );
endinterface

// File: rtl/memory_pipelined_uram_be.sv
// ---------------------------------------------------------------------------
// memory_pipelined_uram_be
// Purpose : 1R1W UltraRAM buffer with byte-lane writes, a RAM output register
//           followed by PIPE pipeline stages, per-slot valid / out-of-range
//           tracking and selectable read-during-write behaviour.
// Ports   : CE   - clock, rising edge
//           RSTB - asynchronous active-low reset (clears pipeline, not RAM)
//           bus  - request/return bundle (slave side)
// Timing  : a read sampled on edge t appears on O/O_valid after edge t+PIPE,
//           i.e. 1+PIPE edges counting the sampling edge.
// ---------------------------------------------------------------------------
module memory_pipelined_uram_be #(
    parameter int DW      = 512,
    parameter int DEPTH   = 512,
    parameter int AW      = 9,
    parameter int PIPE    = 2,
    parameter int RDW_NEW = 0
) (
    input  logic                        CE,
    input  logic                        RSTB,
    memory_pipelined_uram_be_if.slave   bus
);
    localparam int          NB      = DW / 8;
    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Byte-lane merge of an old word with new data under a lane mask.
    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0] old_w,
        input logic [DW-1:0] new_w,
        input logic [NB-1:0] lanes
    );
        logic [DW-1:0] res;
        res = old_w;
        for (int k = 0; k < NB; k++) begin
            if (lanes[k]) begin
                res[8*k +: 8] = new_w[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_w[8*k +: 8];
            end
        end
        return res;
    endfunction

    (* ram_style = "ultra" *) logic [DW-1:0] r_mem_r [DEPTH];

    logic          w_rd_in_s;
    logic          w_wr_in_s;
    logic          w_collide_s;
    logic [DW-1:0] w_old_s;
    logic [DW-1:0] w_rd_data_s;

    logic          r_memreg_v_r;
    logic          r_memreg_oor_r;
    logic [DW-1:0] r_memreg_r;
    logic [DW-1:0] r_pipe_d_r [PIPE];
    logic [PIPE-1:0] r_pipe_v_r;
    logic [PIPE-1:0] r_pipe_oor_r;

    // Address range checks, collision detection and read-data selection.
    always_comb begin
        w_rd_in_s   = ({1'b0, bus.A_read}  < DEPTH_W);
        w_wr_in_s   = ({1'b0, bus.A_write} < DEPTH_W);
        w_old_s     = '0;
        w_rd_data_s = '0;
        if (w_rd_in_s) begin
            w_old_s = r_mem_r[bus.A_read[IW-1:0]];
        end else begin
            w_old_s = '0;
        end
        w_collide_s = bus.CSB_write && w_wr_in_s && w_rd_in_s &&
                      (bus.A_read == bus.A_write);
        // Bubbles and out-of-range slots carry zero so O is 0 whenever it is not real data.
        if (!bus.CSB_read || !w_rd_in_s) begin
            w_rd_data_s = '0;
        end else if ((RDW_NEW != 0) && w_collide_s) begin
            w_rd_data_s = byte_merge(w_old_s, bus.I, bus.WEB);
        end else begin
            w_rd_data_s = w_old_s;
        end
    end

    // Byte-lane RAM write; the array itself is intentionally never reset.
    always_ff @(posedge CE) begin
        if (bus.CSB_write && w_wr_in_s) begin
            for (int k = 0; k < NB; k++) begin
                if (bus.WEB[k]) begin
                    r_mem_r[bus.A_write[IW-1:0]][8*k +: 8] <= bus.I[8*k +: 8];
                end
            end
        end
    end

    // RAM output register plus pipeline; data, valid and oor advance together.
    always_ff @(posedge CE or negedge RSTB) begin
        if (!RSTB) begin
            r_memreg_r     <= '0;
            r_memreg_v_r   <= 1'b0;
            r_memreg_oor_r <= 1'b0;
            for (int s = 0; s < PIPE; s++) begin
                r_pipe_d_r[s] <= '0;
            end
            r_pipe_v_r   <= '0;
            r_pipe_oor_r <= '0;
        end else begin
            r_memreg_r     <= w_rd_data_s;
            r_memreg_v_r   <= bus.CSB_read;
            r_memreg_oor_r <= bus.CSB_read && !w_rd_in_s;
            r_pipe_d_r[0]   <= r_memreg_r;
            r_pipe_v_r[0]   <= r_memreg_v_r;
            r_pipe_oor_r[0] <= r_memreg_oor_r;
            for (int s = 1; s < PIPE; s++) begin
                r_pipe_d_r[s]   <= r_pipe_d_r[s-1];
                r_pipe_v_r[s]   <= r_pipe_v_r[s-1];
                r_pipe_oor_r[s] <= r_pipe_oor_r[s-1];
            end
        end
    end

    // Output enable gates data only; valid and oor flags always reflect the slot.
    always_comb begin
        bus.O       = '0;
        bus.O_valid = r_pipe_v_r[PIPE-1];
        bus.O_oor   = r_pipe_oor_r[PIPE-1];
        if (bus.OEB) begin
            bus.O = '0;
        end else begin
            bus.O = r_pipe_d_r[PIPE-1];
        end
    end
endmodule

// File: tb/tb_memory_pipelined_uram_be.sv
// ---------------------------------------------------------------------------
// tb_memory_pipelined_uram_be
// Purpose : self-checking bench for memory_pipelined_uram_be. Two instances
//           (old-data and new-data read-during-write) share the same stimulus;
//           a word-level memory model plus a table of expected results keyed
//           by the cycle in which each read must appear provides the reference.
// ---------------------------------------------------------------------------
module tb_memory_pipelined_uram_be;
    localparam int DW    = 512;
    localparam int NB    = DW / 8;
    localparam int AW    = 9;
    localparam int DEPTH = 300;
    localparam int PIPE  = 2;
    localparam int LAT   = PIPE + 1;

    logic CE   = 1'b0;
    logic RSTB = 1'b1;

    always #5 CE = ~CE;

    memory_pipelined_uram_be_if #(.DW(DW), .AW(AW)) bus0 ();
    memory_pipelined_uram_be_if #(.DW(DW), .AW(AW)) bus1 ();

    assign bus1.CSB_read  = bus0.CSB_read;
    assign bus1.A_read    = bus0.A_read;
    assign bus1.CSB_write = bus0.CSB_write;
    assign bus1.WEB       = bus0.WEB;
    assign bus1.A_write   = bus0.A_write;
    assign bus1.I         = bus0.I;
    assign bus1.OEB       = bus0.OEB;

    memory_pipelined_uram_be #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .PIPE(PIPE), .RDW_NEW(0))
        dut0 (.CE(CE), .RSTB(RSTB), .bus(bus0.slave));
    memory_pipelined_uram_be #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .PIPE(PIPE), .RDW_NEW(1))
        dut1 (.CE(CE), .RSTB(RSTB), .bus(bus1.slave));

    // Reference: word memory plus expected slot contents per output cycle.
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] e0 [int];
    logic [DW-1:0] e1 [int];
    bit            ev [int];
    bit            eo [int];
    int            cyc;
    int            n_tests;
    int            n_fail;

    function automatic logic [DW-1:0] g_o0(input int c);
        return e0.exists(c) ? e0[c] : '0;
    endfunction
    function automatic logic [DW-1:0] g_o1(input int c);
        return e1.exists(c) ? e1[c] : '0;
    endfunction
    function automatic bit g_v(input int c);
        return ev.exists(c) ? ev[c] : 1'b0;
    endfunction
    function automatic bit g_oor(input int c);
        return eo.exists(c) ? eo[c] : 1'b0;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    // One clock: drive request, record what each read must return, update memory model.
    task automatic step(input bit rd, input int ra, input bit wr,
                        input logic [NB-1:0] web, input int wa, input logic [DW-1:0] wd);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        int key;
        bus0.CSB_read  = rd;
        bus0.A_read    = AW'(ra);
        bus0.CSB_write = wr;
        bus0.WEB       = web;
        bus0.A_write   = AW'(wa);
        bus0.I         = wd;
        key = cyc + LAT;
        if (rd) begin
            ev[key] = 1'b1;
            if (ra >= DEPTH) begin
                eo[key] = 1'b1;
                e0[key] = '0;
                e1[key] = '0;
            end else begin
                eo[key] = 1'b0;
                old_w = mdl[ra];
                new_w = old_w;
                if (wr && wa == ra) begin
                    for (int k = 0; k < NB; k++)
                        if (web[k]) new_w[8*k +: 8] = wd[8*k +: 8];
                end
                e0[key] = old_w;
                e1[key] = new_w;
            end
        end
        if (wr && wa < DEPTH) begin
            for (int k = 0; k < NB; k++)
                if (web[k]) mdl[wa][8*k +: 8] = wd[8*k +: 8];
        end
        @(posedge CE);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, '0, 0, '0);
    endtask

    task automatic clear_expect();
        e0.delete(); e1.delete(); ev.delete(); eo.delete();
    endtask

    task automatic test_reset();
        logic [DW-1:0] a5;
        a5 = {NB{8'hA5}};
        bus0.OEB = 1'b0;
        #1 RSTB = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus0.CSB_read  = 1'($urandom);
            bus0.A_read    = AW'($urandom_range(0, 511));
            bus0.CSB_write = 1'($urandom);
            bus0.WEB       = {$urandom, $urandom};
            bus0.A_write   = AW'($urandom_range(0, 511));
            bus0.I         = rand_word();
            @(posedge CE);
            #1;
            n_tests++;
            if ({bus0.O_valid, bus0.O_oor, bus1.O_valid, bus1.O_oor} !== 4'b0000 ||
                bus0.O !== '0 || bus1.O !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: valid/oor0=%b%b valid/oor1=%b%b O0=%h, required all 0",
                         bus0.O_valid, bus0.O_oor, bus1.O_valid, bus1.O_oor, bus0.O);
            end
        end
        bus0.CSB_read = 1'b0; bus0.CSB_write = 1'b0;
        RSTB = 1'b1;
        cyc = 0;
        clear_expect();
        step(1'b0, 0, 1'b1, '1, 5, a5);
        step(1'b1, 5, 1'b0, '0, 0, '0);
        for (int e = 2; e <= 4; e++) begin
            if (e > 2) idle();
            else idle();
            n_tests++;
            if (bus0.O_valid !== (e == 3) || bus1.O_valid !== (e == 3)) begin
                n_fail++;
                $display("FAIL first_read_valid edge%0d: got %b/%b required %b", e,
                         bus0.O_valid, bus1.O_valid, (e == 3));
            end
            n_tests++;
            if (bus0.O !== ((e == 3) ? a5 : '0)) begin
                n_fail++;
                $display("FAIL first_read_data edge%0d: got %h", e, bus0.O);
            end
        end
    endtask

    task automatic test_init();
        for (int a = 0; a < DEPTH; a++) step(1'b0, 0, 1'b1, '1, a, rand_word());
    endtask

    task automatic test_byte_lanes();
        logic [DW-1:0] req;
        req = {NB{8'hFF}};
        req[7:0]   = 8'h00;
        req[23:16] = 8'h00;
        step(1'b0, 0, 1'b1, '1, 7, {NB{8'hFF}});
        step(1'b0, 0, 1'b1, NB'(4'b0101), 7, '0);
        step(1'b1, 7, 1'b0, '0, 0, '0);
        idle(); idle();
        n_tests++;
        if (bus0.O !== req || bus0.O_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_lanes: got %h valid %b required %h valid 1", bus0.O, bus0.O_valid, req);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int count;
        int start;
        first = -1; count = 0;
        start = cyc + 1;
        for (int a = 0; a < 16 + LAT; a++) begin
            if (a < 16) step(1'b1, a, 1'b0, '0, 0, '0);
            else idle();
            if (bus0.O_valid === 1'b1) begin
                if (first < 0) first = cyc;
                count++;
            end
            n_tests++;
            if (bus0.O_valid !== g_v(cyc) || bus0.O !== g_o0(cyc) || bus1.O !== g_o1(cyc)) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: valid %b O0 %h required valid %b O0 %h",
                         cyc, bus0.O_valid, bus0.O, g_v(cyc), g_o0(cyc));
            end
        end
        n_tests++;
        if (count != 16 || first != start + PIPE) begin
            n_fail++;
            $display("FAIL b2b_count: %0d valid cycles first at %0d, required 16 at %0d",
                     count, first, start + PIPE);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d11;
        logic [DW-1:0] d22;
        d11 = {NB{8'h11}};
        d22 = {NB{8'h22}};
        step(1'b0, 0, 1'b1, '1, 9, d11);
        step(1'b1, 9, 1'b1, '1, 9, d22);
        idle(); idle();
        n_tests++;
        if (bus0.O !== d11 || bus1.O !== d22) begin
            n_fail++;
            $display("FAIL collision: old-build %h new-build %h required %h / %h", bus0.O, bus1.O, d11, d22);
        end
        step(1'b1, 9, 1'b0, '0, 0, '0);
        idle(); idle();
        n_tests++;
        if (bus0.O !== d22 || bus1.O !== d22) begin
            n_fail++;
            $display("FAIL collision_followup: %h / %h required %h", bus0.O, bus1.O, d22);
        end
    endtask

    task automatic test_oor();
        logic [DW-1:0] w299;
        step(1'b0, 0, 1'b1, '1, 301, {NB{8'h33}});
        w299 = mdl[299];
        step(1'b1, 301, 1'b0, '0, 0, '0);
        step(1'b1, 299, 1'b0, '0, 0, '0);
        idle();
        n_tests++;
        if (bus0.O !== '0 || bus0.O_valid !== 1'b1 || bus0.O_oor !== 1'b1 || bus1.O_oor !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_read: O %h valid %b oor %b required O 0 valid 1 oor 1",
                     bus0.O, bus0.O_valid, bus0.O_oor);
        end
        idle();
        n_tests++;
        if (bus0.O !== w299 || bus0.O_valid !== 1'b1 || bus0.O_oor !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_neighbour: O %h valid %b oor %b required %h valid 1 oor 0",
                     bus0.O, bus0.O_valid, bus0.O_oor, w299);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 3, 1'b0, '0, 0, '0);
        step(1'b1, 4, 1'b0, '0, 0, '0);
        bus0.CSB_read = 1'b0; bus0.CSB_write = 1'b0;
        RSTB = 1'b0;
        clear_expect();
        @(posedge CE);
        #1;
        cyc++;
        RSTB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) idle();
            n_tests++;
            if (bus0.O_valid !== 1'b0 || bus1.O_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midflight_reset %0d: valid %b/%b required 0", i, bus0.O_valid, bus1.O_valid);
            end
        end
    endtask

    task automatic test_oeb();
        step(1'b1, 10, 1'b0, '0, 0, '0);
        idle(); idle();
        bus0.OEB = 1'b1;
        #1;
        n_tests++;
        if (bus0.O !== '0 || bus0.O_valid !== 1'b1 || bus1.O !== '0) begin
            n_fail++;
            $display("FAIL oeb_gate: O %h valid %b required O 0 valid 1", bus0.O, bus0.O_valid);
        end
        bus0.OEB = 1'b0;
        #1;
        n_tests++;
        if (bus0.O !== mdl[10]) begin
            n_fail++;
            $display("FAIL oeb_release: O %h required %h", bus0.O, mdl[10]);
        end
    endtask

    task automatic test_random();
        int ra;
        int wa;
        for (int i = 0; i < 400; i++) begin
            ra = $urandom_range(0, 319);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 319);
            bus0.OEB = ($urandom_range(0, 7) == 0);
            if (i >= 400 - LAT) step(1'b0, 0, 1'b0, '0, 0, '0);
            else step(1'($urandom), ra, 1'($urandom), {$urandom, $urandom}, wa, rand_word());
            n_tests++;
            if ({bus0.O_valid, bus0.O_oor, bus1.O_valid, bus1.O_oor} !==
                    {g_v(cyc), g_oor(cyc), g_v(cyc), g_oor(cyc)} ||
                bus0.O !== (bus0.OEB ? '0 : g_o0(cyc)) ||
                bus1.O !== (bus0.OEB ? '0 : g_o1(cyc))) begin
                n_fail++;
                $display("FAIL random cyc%0d: v/oor %b%b%b%b required %b%b O0 %h required %h",
                         cyc, bus0.O_valid, bus0.O_oor, bus1.O_valid, bus1.O_oor,
                         g_v(cyc), g_oor(cyc), bus0.O, bus0.OEB ? '0 : g_o0(cyc));
            end
        end
        bus0.OEB = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        bus0.CSB_read  = 1'b0;
        bus0.A_read    = '0;
        bus0.CSB_write = 1'b0;
        bus0.WEB       = '0;
        bus0.A_write   = '0;
        bus0.I         = '0;
        bus0.OEB       = 1'b0;
        test_reset();
        test_init();
        test_byte_lanes();
        test_back_to_back();
        test_collision();
        test_oor();
        test_reset_midflight();
        test_oeb();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
